// File: rtl/asyncf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : asyncf_arb_pkg
// Description : Shared state type and circular priority search for the
//               asyncf write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package asyncf_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int c_ARB_MAX_REQ = 8;

    // Returns {found, idx}; the search wraps at num, so start must be < num.
    function automatic logic [3:0] rr_pick(
        input logic [c_ARB_MAX_REQ-1:0] req,
        input logic [2:0]               start,
        input int                       num
    );
        logic [3:0] res;
        int         pos;
        res = '0;
        for (int k = 0; k < c_ARB_MAX_REQ; k++) begin
            pos = int'(start) + k;
            if (pos >= num) begin
                pos = pos - num;
            end
            if ((k < num) && !res[3] && req[pos[2:0]]) begin
                res = {1'b1, pos[2:0]};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/asyncf_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : asyncf_rr_pick
// Description : Combinational circular priority encoder; finds the first set
//               request at or after start, wrapping at NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module asyncf_rr_pick
    import asyncf_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [c_ARB_MAX_REQ-1:0] w_req_ext;
    logic [2:0]               w_start_ext;
    logic [3:0]               w_pick;

    assign w_req_ext   = c_ARB_MAX_REQ'(req);
    assign w_start_ext = 3'(start);
    assign w_pick      = rr_pick(w_req_ext, w_start_ext, NUM_REQ);

    assign found = w_pick[3];
    assign idx   = IDX_W'(w_pick[2:0]);

endmodule
`default_nettype wire

// File: rtl/asyncf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : asyncf_wr_arbiter
// Description : Round-robin arbiter sharing the async FIFO write port among
//               NUM_REQ producers. Define ASYNCF_ARB_BURST_EN for burst
//               locking (up to BURST_LEN beats per grant).
// Revision    : 1.0 - initial release
// ============================================================================
module asyncf_wr_arbiter
    import asyncf_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                       wclk,
    input  logic                       wrst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DSIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DSIZE-1:0]           wdata,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

    localparam int                 c_IDX_W   = $clog2(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST_ID = c_IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_IDX_W-1:0] r_gnt_id;
    logic [c_IDX_W-1:0] w_gnt_id_nxt;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] w_rr_ptr_nxt;
    logic [c_IDX_W-1:0] w_rel_start;
    logic [c_IDX_W-1:0] w_idle_idx;
    logic [c_IDX_W-1:0] w_rel_idx;
    logic               w_idle_found;
    logic               w_rel_found;
    logic               w_own_valid;
    logic               w_active;
    logic               w_xfer;
    logic               w_last_beat;
    logic               w_release;
    logic [DSIZE-1:0]   w_data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
    end

    // Reset suppresses the in-flight beat so nothing is written while wrst=1.
    assign w_active    = (r_state == ARB_GRANT) && !wrst;
    assign w_own_valid = req_valid[r_gnt_id];
    assign w_xfer      = w_active && w_own_valid && !wfull;
    assign w_release   = (r_state == ARB_GRANT) && (w_xfer ? w_last_beat : !w_own_valid);
    assign w_rel_start = (r_gnt_id == c_LAST_ID) ? '0 : r_gnt_id + 1'b1;

    asyncf_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_pick_idle (
        .req   (req_valid),
        .start (r_rr_ptr),
        .found (w_idle_found),
        .idx   (w_idle_idx)
    );

    // Starting just past the grantee searches the releasing requester last.
    asyncf_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_pick_rel (
        .req   (req_valid),
        .start (w_rel_start),
        .found (w_rel_found),
        .idx   (w_rel_idx)
    );

`ifdef ASYNCF_ARB_BURST_EN
    localparam logic [7:0] c_BEAT_LAST = 8'(BURST_LEN - 1);

    logic [7:0] r_beat_cnt;
    logic [7:0] w_beat_cnt_nxt;

    assign w_last_beat = (r_beat_cnt == c_BEAT_LAST);

    always_comb begin
        w_beat_cnt_nxt = r_beat_cnt;
        if ((r_state == ARB_IDLE) || w_release) begin
            w_beat_cnt_nxt = '0;
        end else if (w_xfer) begin
            w_beat_cnt_nxt = r_beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_beat_cnt <= '0;
        end else begin
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
`else
    // Burst length collapses to a single beat: rotate after every transfer.
    localparam int c_EFF_BURST = (BURST_LEN > 0) ? 1 : 1;

    assign w_last_beat = (c_EFF_BURST == 1);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_id_nxt = r_gnt_id;
        w_rr_ptr_nxt = r_rr_ptr;
        if (r_state == ARB_IDLE) begin
            if (w_idle_found) begin
                w_state_nxt  = ARB_GRANT;
                w_gnt_id_nxt = w_idle_idx;
            end
        end else if (w_release) begin
            w_rr_ptr_nxt = w_rel_start;
            if (w_rel_found) begin
                w_gnt_id_nxt = w_rel_idx;
            end else begin
                w_state_nxt = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state  <= ARB_IDLE;
            r_gnt_id <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_active && !wfull) begin
            req_ready[r_gnt_id] = 1'b1;
        end
    end

    assign winc      = w_xfer;
    assign wdata     = w_xfer ? w_data_arr[r_gnt_id] : '0;
    assign gnt_valid = (r_state == ARB_GRANT);
    assign gnt_id    = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_asyncf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_asyncf_wr_arbiter
// Description : Self-checking bench for asyncf_wr_arbiter; write order and
//               data are checked against an expected-beat queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asyncf_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DSIZE     = 8;
    localparam int BURST_LEN = 4;
`ifdef ASYNCF_ARB_BURST_EN
    localparam int EFF = BURST_LEN;
`else
    localparam int EFF = 1;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    logic                     wclk = 1'b0;
    logic                     wrst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DSIZE-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     wfull;
    logic                     winc;
    logic [DSIZE-1:0]         wdata;
    logic                     gnt_valid;
    logic [1:0]               gnt_id;

    beat_t      sb_q[$];
    beat_t      mon_exp;
    logic [3:0] mon_rdy;
    logic       sb_en = 1'b0;
    int         total = 0;
    int         bad   = 0;

    asyncf_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DSIZE     (DSIZE),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 wclk = ~wclk;

    // Every FIFO write must match the head of the expected-beat queue.
    always @(negedge wclk) begin
        if (sb_en && winc) begin
            total = total + 1;
            if (sb_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_extra: write id=%0d data=%h, required no write", gnt_id, wdata);
            end else begin
                mon_exp = sb_q.pop_front();
                if (wdata !== mon_exp.data || gnt_id !== mon_exp.id) begin
                    bad = bad + 1;
                    $display("FAIL sb_beat: got id=%0d data=%h, required id=%0d data=%h",
                             gnt_id, wdata, mon_exp.id, mon_exp.data);
                end
            end
            total = total + 1;
            mon_rdy = 4'b0001 << gnt_id;
            if (req_ready !== mon_rdy) begin
                bad = bad + 1;
                $display("FAIL sb_ready: got %b, required %b", req_ready, mon_rdy);
            end
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic push_exp(input int id);
        beat_t b;
        b.id   = 2'(id);
        b.data = 8'hA0 + 8'(id);
        sb_q.push_back(b);
    endtask

    task automatic do_reset();
        sb_en     = 1'b0;
        wrst      = 1'b1;
        wfull     = 1'b0;
        req_valid = '0;
        step();
        wrst = 1'b0;
        sb_q.delete();
        sb_en = 1'b1;
    endtask

    task automatic test_reset();
        sb_en     = 1'b0;
        wrst      = 1'b1;
        wfull     = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 2; c++) begin
            @(negedge wclk);
            total = total + 3;
            if (winc !== 1'b0) begin bad = bad + 1; $display("FAIL rst_winc: got %b, required 0", winc); end
            if (req_ready !== 4'b0) begin bad = bad + 1; $display("FAIL rst_ready: got %b, required 0000", req_ready); end
            if (gnt_valid !== 1'b0) begin bad = bad + 1; $display("FAIL rst_gnt_valid: got %b, required 0", gnt_valid); end
            step();
        end
        wrst = 1'b0;
        @(negedge wclk);
        total = total + 1;
        if (gnt_valid !== 1'b0 || winc !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL rst_idle_cycle: got gnt_valid=%b winc=%b, required 0 0", gnt_valid, winc);
        end
        step();
        @(negedge wclk);
        total = total + 2;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
            bad = bad + 1;
            $display("FAIL rst_first_grant: got valid=%b id=%0d, required 1 0", gnt_valid, gnt_id);
        end
        if (winc !== 1'b1 || wdata !== 8'hA0) begin
            bad = bad + 1;
            $display("FAIL rst_first_write: got winc=%b data=%h, required 1 a0", winc, wdata);
        end
        step();
        req_valid = '0;
        step();
        step();
    endtask

    // Continuous stream from the requesters in 'mask'; ids rotate every EFF beats.
    task automatic run_stream(input logic [3:0] mask, input int id_a, input int id_b,
                              input int n_ids, input int n_beats, input int stall_at);
        int id;
        do_reset();
        req_valid = mask;
        for (int k = 0; k < n_beats; k++) begin
            if (n_ids == 4) id = (k / EFF) % 4;
            else id = (((k / EFF) % 2) == 0) ? id_a : id_b;
            push_exp(id);
        end
        @(negedge wclk);
        total = total + 1;
        if (gnt_valid !== 1'b0) begin bad = bad + 1; $display("FAIL stream_idle: got gnt_valid=%b, required 0", gnt_valid); end
        step();
        for (int k = 0; k < n_beats; k++) begin
            if (k == stall_at) begin
                if (n_ids == 4) id = (k / EFF) % 4;
                else id = (((k / EFF) % 2) == 0) ? id_a : id_b;
                wfull = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge wclk);
                    total = total + 2;
                    if (winc !== 1'b0 || req_ready !== 4'b0) begin
                        bad = bad + 1;
                        $display("FAIL bp_stall: got winc=%b ready=%b, required 0 0000", winc, req_ready);
                    end
                    if (gnt_valid !== 1'b1 || gnt_id !== 2'(id)) begin
                        bad = bad + 1;
                        $display("FAIL bp_hold: got valid=%b id=%0d, required 1 %0d", gnt_valid, gnt_id, id);
                    end
                    step();
                end
                wfull = 1'b0;
            end
            @(negedge wclk);
            total = total + 1;
            if (winc !== 1'b1) begin bad = bad + 1; $display("FAIL stream_continuous: beat %0d winc=%b, required 1", k, winc); end
            step();
        end
        req_valid = '0;
        step();
        step();
        total = total + 1;
        if (sb_q.size() != 0) begin bad = bad + 1; $display("FAIL stream_drain: %0d beats missing, required 0", sb_q.size()); end
    endtask

    task automatic test_fairness();
        run_stream(4'b1111, 0, 0, 4, 16, -1);
    endtask

    task automatic test_burst();
        run_stream(4'b0110, 1, 2, 2, 12, -1);
    endtask

    task automatic test_backpressure();
        run_stream(4'b0011, 0, 1, 2, 8, 2);
    endtask

    task automatic test_early_drop();
        do_reset();
        req_valid = 4'b1001;
        push_exp(0);
        @(negedge wclk);
        step();
        @(negedge wclk);
        total = total + 1;
        if (gnt_id !== 2'd0 || winc !== 1'b1) begin bad = bad + 1; $display("FAIL ed_first: got id=%0d winc=%b, required 0 1", gnt_id, winc); end
        step();
        req_valid[0] = 1'b0;
        if (EFF > 1) begin
            @(negedge wclk);
            total = total + 1;
            if (winc !== 1'b0 || gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
                bad = bad + 1;
                $display("FAIL ed_release_cycle: got winc=%b valid=%b id=%0d, required 0 1 0", winc, gnt_valid, gnt_id);
            end
            step();
        end
        push_exp(3);
        @(negedge wclk);
        total = total + 1;
        if (gnt_id !== 2'd3 || winc !== 1'b1) begin bad = bad + 1; $display("FAIL ed_new_grant: got id=%0d winc=%b, required 3 1", gnt_id, winc); end
        step();
        req_valid = '0;
        step();
        @(negedge wclk);
        total = total + 1;
        if (gnt_valid !== 1'b0) begin bad = bad + 1; $display("FAIL ed_idle: got gnt_valid=%b, required 0", gnt_valid); end
        // Lone requester 0 drops after one beat; rr_ptr must then sit at 1.
        step();
        req_valid = 4'b0001;
        push_exp(0);
        step();
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0011;
        push_exp(1);
        step();
        @(negedge wclk);
        total = total + 1;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin bad = bad + 1; $display("FAIL ed_rr_advance: got valid=%b id=%0d, required 1 1", gnt_valid, gnt_id); end
        step();
        req_valid = '0;
        step();
        step();
        total = total + 1;
        if (sb_q.size() != 0) begin bad = bad + 1; $display("FAIL ed_drain: %0d beats missing, required 0", sb_q.size()); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req_valid = 4'b0010;
        push_exp(1);
        step();
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0100;
        push_exp(2);
        step();
        @(negedge wclk);
        total = total + 1;
        if (gnt_id !== 2'd2 || winc !== 1'b1) begin bad = bad + 1; $display("FAIL mr_beat0: got id=%0d winc=%b, required 2 1", gnt_id, winc); end
        step();
        wrst = 1'b1;
        @(negedge wclk);
        total = total + 1;
        if (winc !== 1'b0 || req_ready !== 4'b0) begin
            bad = bad + 1;
            $display("FAIL mr_no_write: got winc=%b ready=%b, required 0 0000", winc, req_ready);
        end
        step();
        wrst      = 1'b0;
        req_valid = 4'b1001;
        push_exp(0);
        @(negedge wclk);
        total = total + 1;
        if (gnt_valid !== 1'b0) begin bad = bad + 1; $display("FAIL mr_idle: got gnt_valid=%b, required 0", gnt_valid); end
        step();
        @(negedge wclk);
        total = total + 1;
        if (gnt_id !== 2'd0 || winc !== 1'b1) begin bad = bad + 1; $display("FAIL mr_fresh_grant: got id=%0d winc=%b, required 0 1", gnt_id, winc); end
        step();
        req_valid = '0;
        step();
        step();
        total = total + 1;
        if (sb_q.size() != 0) begin bad = bad + 1; $display("FAIL mr_drain: %0d beats missing, required 0", sb_q.size()); end
    endtask

    initial begin
        wrst      = 1'b1;
        wfull     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DSIZE +: DSIZE] = 8'hA0 + 8'(i);
        end
        test_reset();
        test_fairness();
        test_burst();
        test_backpressure();
        test_early_drop();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/asyncf_wr_arbiter.md
# asyncf_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO. Shares the FIFO's single write-domain port (`winc`/`wdata`/`wfull`) among `NUM_REQ` producers. Sits entirely in the write clock domain, directly in front of the FIFO write interface. Supports optional burst locking, so one producer keeps the port for several consecutive writes.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DSIZE`, 8: data width; matches the FIFO `DSIZE`.
- `BURST_LEN`, 4: maximum beats per grant when burst locking is compiled in, 1..255.
- `wclk`  in  1  write-domain clock; the only clock.
- `wrst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_data`  in  NUM_REQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE].
- `req_ready`  out  NUM_REQ  per-requester accept; transfer when valid && ready.
- `wfull`  in  1  FIFO full flag, write domain.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `gnt_valid`  out  1  a grant is held.
- `gnt_id`  out  $clog2(NUM_REQ)  current grantee.

## Operation
- FSM has two states, IDLE and GRANT. Registered state: `state`, `gnt_id`, `rr_ptr` (next priority start), `beat_cnt` (8 bits).
- IDLE with any `req_valid`: pick the first set bit searching circularly from `rr_ptr`. Load `gnt_id`, clear `beat_cnt`, move to GRANT.
- In GRANT:
  - `req_ready[gnt_id] = !wfull`; every other `req_ready` is 0.
  - `winc = req_valid[gnt_id] && !wfull`.
  - `wdata = req_data[gnt_id]` (don't-care when `winc`=0).
- Each transfer increments `beat_cnt`.
- Release occurs on either event:
  - a transfer when `beat_cnt+1 == BURST_LEN`;
  - `req_valid[gnt_id]`=0 in a cycle with no transfer.
- On release:
  - set `rr_ptr = gnt_id+1` (mod NUM_REQ);
  - re-arbitrate in the same cycle from `gnt_id+1` over current `req_valid`, with the releasing requester searched last;
  - if any request is found, load the new grant and stay in GRANT; otherwise go to IDLE.
- wfull=1 in GRANT: stall. No transfer, `beat_cnt` held, grant held indefinitely (no timeout, no release).
- Requesters must hold `req_data` stable while valid and not accepted.
- `gnt_valid = (state==GRANT)`.

## Timing
- Reset values: `state`=IDLE, `gnt_id`=0, `rr_ptr`=0, `beat_cnt`=0. All outputs 0 (`winc`, `req_ready`, `gnt_valid`, `gnt_id`, `wdata`).
- Arbitration latency from IDLE: a request is seen at edge N, grant is held after edge N, and the first `winc` can occur in cycle N+1. The IDLE→GRANT transition always costs 1 cycle.
- Back-to-back grants (release with another pending request) have no bubble. `winc` may stay high across the grant change.
- `winc`, `wdata` and `req_ready` are combinational from the registered grant plus `req_valid`/`wfull`. There is no path from `req_valid` to `req_ready`.
- `wrst` mid-burst: the next edge forces IDLE and `rr_ptr`=0. The in-flight beat in the reset cycle is not written (`winc`=0 while `wrst`=1).
- `beat_cnt` never exceeds `BURST_LEN`-1 and never wraps.

## Configuration
- `ASYNCF_ARB_BURST_EN` defined: burst locking as described, releasing after `BURST_LEN` beats.
- Not defined: effective `BURST_LEN`=1. Release after every transfer and rotate per beat. `beat_cnt` logic is removed and `BURST_LEN` is ignored.

## Structure
- Shared package `asyncf_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t`;
  - function `rr_pick(req, start)`, returning `{found, idx}`.
- One natural sub-module: `asyncf_rr_pick`, a combinational circular priority encoder with NUM_REQ/start inputs. It is instanced twice (IDLE pick, release re-pick) or shared via a muxed `start`.

## Test plan
- Reset: hold `wrst` 2 cycles with all `req_valid`=1. Required: `winc`=0, `req_ready`=0, `gnt_valid`=0. After release, the first grant is `gnt_id`=0, asserted 1 cycle later.
- Fairness, no burst: all 4 requesters hold valid with data 8'hA0+i, `wfull`=0. Required: `wdata` sequence A0,A1,A2,A3,A0… with `winc` continuous after the first grant.
- Burst, with `ASYNCF_ARB_BURST_EN` and `BURST_LEN`=4: requesters 1 and 2 valid. Required: 4 beats from 1, then 4 from 2, then 1 again, with no bubble at switches.
- Backpressure: `wfull`=1 for 5 cycles mid-burst at beat 2. Required: `winc`=0 and `req_ready`=0 throughout, grant held, `beat_cnt`=2. After `wfull` falls, beats 2 and 3 complete, then release.
- Early drop: the grantee deasserts valid after 1 beat while requester 3 is pending. Required: a no-transfer cycle releases the grant, `gnt_id`=3 next cycle, and `rr_ptr` advances past the dropper.
- Reset mid-burst: assert `wrst` at beat 1 of requester 2. Required: `winc`=0 that cycle, then IDLE, then a fresh grant starting search from 0.
